// File: rtl/cpc_fifo_host_ctrl.sv
// Host-side CPC-Pi FIFO link controller: decodes Z80 I/O cycles into a data and a
// status/control port and sequences the 40105 FIFO strobes, stretching the bus with READY.
module cpc_fifo_host_ctrl #(
    parameter logic [15:0] DATA_PORT  = 16'hFD80,
    parameter logic [15:0] STAT_PORT  = 16'hFD81,
    parameter logic [15:0] ADDR_MASK  = 16'hFFFF,
    parameter int unsigned SI_CYCLES  = 2,
    parameter int unsigned SOB_CYCLES = 2,
    parameter int unsigned MR_CYCLES  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic        fifo_host_dir,
    input  logic        fifo_host_dor,
    output logic        host_fifo_si,
    output logic        host_fifo_sob,
    output logic        host_fifo_oeb,
    output logic        host_fifo_reset,
    output logic        READY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SI,
        ST_RD_DATA,
        ST_RD_SO,
        ST_RD_STAT,
        ST_MR,
        ST_WAIT_END
    } state_e;

    localparam logic [2:0] SI_LOAD  = 3'(SI_CYCLES - 1);
    localparam logic [2:0] SOB_LOAD = 3'(SOB_CYCLES - 1);
    localparam logic [2:0] MR_LOAD  = 3'(MR_CYCLES - 1);

    // Registered bus and FIFO flag inputs
    logic [15:0] a_q;
    logic        ioreq_q, rd_q, wr_q, din0_q, dir_q, dor_q;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic        stat_rd_q, stat_rd_d;
    logic        si_q, si_d, sob_q, sob_d, oeb_q, oeb_d, mr_q, mr_d;
    logic        ready_q, ready_d, doe_q, doe_d;
    logic [7:0]  dout_q, dout_d;

    logic        hit_data, hit_stat, io_active, access, rd_act, wr_act;

    // Only bit 0 of the written byte carries meaning (master-reset request)
    logic        unused_din;
    assign unused_din = ^D_in[7:1];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_q     <= '0;
            ioreq_q <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            din0_q  <= 1'b0;
            dir_q   <= 1'b0;
            dor_q   <= 1'b0;
        end else begin
            a_q     <= A;
            ioreq_q <= IOREQ_B;
            rd_q    <= RD_B;
            wr_q    <= WR_B;
            din0_q  <= D_in[0];
            dir_q   <= fifo_host_dir;
            dor_q   <= fifo_host_dor;
        end
    end

    assign hit_data  = ((a_q ^ DATA_PORT) & ADDR_MASK) == 16'h0000;
    assign hit_stat  = ((a_q ^ STAT_PORT) & ADDR_MASK) == 16'h0000;
    assign rd_act    = !rd_q;
    assign wr_act    = !wr_q;
    assign io_active = !ioreq_q && (rd_act || wr_act);
    assign access    = io_active && (hit_data || hit_stat);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        stat_rd_d = stat_rd_q;
        si_d      = 1'b0;
        sob_d     = 1'b1;
        oeb_d     = 1'b1;
        mr_d      = 1'b0;
        ready_d   = 1'b1;
        doe_d     = 1'b0;
        dout_d    = dout_q;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (hit_data && wr_act) begin
                        if (dir_q) begin
                            state_d = ST_WR_SI;
                            cnt_d   = SI_LOAD;
                            si_d    = 1'b1;
                            ready_d = 1'b0;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = ST_WAIT_END;
                        end
                    end else if (hit_data) begin
                        if (dor_q) begin
                            state_d = ST_RD_DATA;
                            oeb_d   = 1'b0;
                        end else begin
                            // Empty FIFO: answer 0xFF ourselves instead of enabling it
                            state_d   = ST_RD_STAT;
                            doe_d     = 1'b1;
                            dout_d    = 8'hFF;
                            unf_d     = 1'b1;
                            stat_rd_d = 1'b0;
                        end
                    end else if (rd_act) begin
                        state_d   = ST_RD_STAT;
                        doe_d     = 1'b1;
                        dout_d    = {ovf_q, unf_q, 4'b0000, dir_q, dor_q};
                        stat_rd_d = 1'b1;
                    end else if (din0_q) begin
                        state_d = ST_MR;
                        cnt_d   = MR_LOAD;
                        mr_d    = 1'b1;
                        ready_d = 1'b0;
                        ovf_d   = 1'b0;
                        unf_d   = 1'b0;
                    end else begin
                        state_d = ST_WAIT_END;
                    end
                end
            end

            ST_WR_SI: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_WAIT_END;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    si_d    = 1'b1;
                    ready_d = 1'b0;
                end
            end

            ST_RD_DATA: begin
                if (!rd_act) begin
                    state_d = ST_RD_SO;
                    cnt_d   = SOB_LOAD;
                    sob_d   = 1'b0;
                end else begin
                    oeb_d = 1'b0;
                end
            end

            // A new access arriving here is held off until IDLE can accept it
            ST_RD_SO: begin
                ready_d = !access;
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    sob_d = 1'b0;
                end
            end

            ST_RD_STAT: begin
                if (!rd_act) begin
                    state_d = ST_IDLE;
                    if (stat_rd_q) begin
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                    end
                end else begin
                    doe_d = 1'b1;
                end
            end

            ST_MR: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_WAIT_END;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    mr_d    = 1'b1;
                    ready_d = !access;
                end
            end

            ST_WAIT_END: begin
                if (ioreq_q) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            stat_rd_q <= 1'b0;
            si_q      <= 1'b0;
            sob_q     <= 1'b1;
            oeb_q     <= 1'b1;
            mr_q      <= 1'b1;
            ready_q   <= 1'b1;
            doe_q     <= 1'b0;
            dout_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            stat_rd_q <= stat_rd_d;
            si_q      <= si_d;
            sob_q     <= sob_d;
            oeb_q     <= oeb_d;
            mr_q      <= mr_d;
            ready_q   <= ready_d;
            doe_q     <= doe_d;
            dout_q    <= dout_d;
        end
    end

    assign host_fifo_si    = si_q;
    assign host_fifo_sob   = sob_q;
    assign host_fifo_oeb   = oeb_q;
    assign host_fifo_reset = mr_q;
    assign READY           = ready_q;
    assign D_oe            = doe_q;
    assign D_out           = dout_q;

endmodule
